l4_slot_scheduler: RTL and testbench
====================================

L4_SLOT_SCHEDULER -- requirements
Module: L4_slot_scheduler

Interface
REQ-001 Parameter: SBITS, 4, width of each slot status code.
REQ-002 Parameter: ST_EMPTY, 4'h0, status code for a free slot.
REQ-003 Parameter: ST_ALLOC, 4'h1, status code for a slot granted to a writer and being filled.
REQ-004 Parameter: ST_FULL, 4'h2, status code for a filled slot queued for read.
REQ-005 Parameter: ST_DRAIN, 4'h3, status code for a slot being read out.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-007 Port: clk  in  1  rising-edge clock.
REQ-008 Port: resetn  in  1  asynchronous active-low reset.
REQ-009 Port: flush  in  1  synchronous clear of all slots, owners and the read queue.
REQ-010 Port: req  in  4  per-writer slot request, level.
REQ-011 Port: done_wr  in  4  per-writer single-cycle pulse: owned slot filled.
REQ-012 Port: gnt  out  4  one-hot single-cycle grant pulse.
REQ-013 Port: gnt_slot  out  2  slot index granted, valid with gnt.
REQ-014 Port: rd_valid  out  1  a FULL slot is offered to the reader.
REQ-015 Port: rd_slot  out  2  offered slot index, stable while rd_valid.
REQ-016 Port: rd_ack  in  1  reader accepts the offer.
REQ-017 Port: rd_done  in  1  single-cycle pulse: reader finished draining.
REQ-018 Port: slot_status  out  16  4 slots x SBITS codes, slot 0 in [3:0].
REQ-019 Port: free_count  out  3  number of slots in ST_EMPTY, 0..4.

Function
REQ-020 Each of the 4 slots SHALL hold a registered SBITS-bit status; transitions: EMPTY->ALLOC on grant, ALLOC->FULL on owner done_wr, FULL->DRAIN on rd_valid&rd_ack, DRAIN->EMPTY on rd_done.
REQ-021 Grant eligibility: writer asserts req and owns no slot; at least one slot reads ST_EMPTY in the current registered status.
REQ-022 At most one grant per cycle; writer chosen round-robin, priority starting one above the last granted writer (writer 0 first after reset).
REQ-023 Granted slot SHALL be the lowest-index ST_EMPTY slot; gnt/gnt_slot are registered, asserted the cycle after the decision, for exactly one cycle.
REQ-024 Owner table SHALL record writer->slot at grant; done_wr from a writer with no owned slot SHALL be ignored; done_wr clears ownership.
REQ-025 On done_wr the slot index SHALL be pushed into a 4-entry FIFO read queue; FULL slots are offered strictly in completion order.
REQ-026 Multiple done_wr in one cycle SHALL be pushed in ascending writer index order within that cycle (queue cannot overflow: at most 4 slots).
REQ-027 Read FSM: R_IDLE (queue empty, rd_valid=0) -> R_OFFER (rd_valid=1, rd_slot=queue head) -> on rd_ack pop and go to R_BUSY -> on rd_done go to R_IDLE (or R_OFFER if queue non-empty).
REQ-028 rd_done outside R_BUSY and rd_ack outside R_OFFER SHALL be ignored.
REQ-029 A slot returned to ST_EMPTY by rd_done SHALL NOT be granted in the same cycle; it is eligible from the next cycle.
REQ-030 free_count SHALL equal the count of ST_EMPTY slots in registered status, updated the cycle after each transition.
REQ-031 flush SHALL set all slots to ST_EMPTY, clear owners and queue, force R_IDLE, and suppress any grant that cycle; flush has priority over all other inputs.

Reset
REQ-032 On resetn low: all slots ST_EMPTY, owners clear, queue empty, read FSM R_IDLE, round-robin pointer to writer 0, gnt=0, gnt_slot=0, rd_valid=0, rd_slot=0, free_count=4.
REQ-033 Reset mid-operation SHALL abandon all in-flight grants and reads with no residual pulses after release.

Verification
REQ-034 req=4'b1111 held after reset -> gnt 0001/slot0, 0010/slot1, 0100/slot2, 1000/slot3 on consecutive cycles; free_count 4->0; no further gnt.
REQ-035 done_wr writers 2 then 0 on separate cycles -> rd_valid with rd_slot=2 first; after rd_ack and rd_done, rd_slot=0 offered.
REQ-036 done_wr=4'b1010 same cycle -> queue order slot of writer1 then writer3.
REQ-037 All slots full, rd_done for slot 1 while req[0] high -> no gnt that cycle; gnt=0001, gnt_slot=1 next cycle.
REQ-038 flush while rd_valid=1 and two slots ALLOC -> next cycle slot_status=16'h0000, free_count=4, rd_valid=0, no gnt.
REQ-039 done_wr from writer with no slot, rd_done in R_IDLE -> no status change.

Source files
------------

// File: rtl/l4_slot_scheduler.sv
// Four-slot buffer scheduler: round-robin grants of free slots to four writers,
// completion-ordered read queue and a single-reader offer/drain handshake.
module l4_slot_scheduler #(
    parameter int unsigned      SBITS    = 4,
    parameter logic [SBITS-1:0] ST_EMPTY = SBITS'(4'h0),
    parameter logic [SBITS-1:0] ST_ALLOC = SBITS'(4'h1),
    parameter logic [SBITS-1:0] ST_FULL  = SBITS'(4'h2),
    parameter logic [SBITS-1:0] ST_DRAIN = SBITS'(4'h3)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic [3:0]            req,
    input  logic [3:0]            done_wr,
    output logic [3:0]            gnt,
    output logic [1:0]            gnt_slot,
    output logic                  rd_valid,
    output logic [1:0]            rd_slot,
    input  logic                  rd_ack,
    input  logic                  rd_done,
    output logic [4*SBITS-1:0]    slot_status,
    output logic [2:0]            free_count
);

    localparam int unsigned NW = 4;
    localparam int unsigned NS = 4;
    localparam int unsigned SW = 2;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {R_IDLE, R_OFFER, R_BUSY} r_state_e;

    logic [SBITS-1:0] status_q [NS];
    logic [SBITS-1:0] status_d [NS];
    logic [NW-1:0]    own_vld_q, own_vld_d;
    logic [SW-1:0]    own_slot_q [NW];
    logic [SW-1:0]    own_slot_d [NW];
    logic [SW-1:0]    rq_mem_q [NS];
    logic [SW-1:0]    rq_mem_d [NS];
    logic [SW-1:0]    rq_head_q, rq_head_d;
    logic [CW-1:0]    rq_cnt_q, rq_cnt_d;
    r_state_e         r_state_q, r_state_d;
    logic [SW-1:0]    drain_slot_q, drain_slot_d;
    logic [SW-1:0]    rr_q, rr_d;
    logic [NW-1:0]    gnt_q, gnt_d;
    logic [SW-1:0]    gnt_slot_q, gnt_slot_d;
    logic             rd_valid_q, rd_valid_d;
    logic [SW-1:0]    rd_slot_q, rd_slot_d;
    logic [CW-1:0]    free_count_q, free_count_d;

    logic             any_empty_c;
    logic [SW-1:0]    empty_slot_c;
    logic             win_vld_c;
    logic [SW-1:0]    win_c;
    logic [SW-1:0]    cand_c;
    logic [SW-1:0]    wr_idx_c;

    // Lowest-index free slot, and round-robin winner starting at rr_q.
    always_comb begin
        any_empty_c  = 1'b0;
        empty_slot_c = '0;
        for (int s = NS - 1; s >= 0; s--) begin
            if (status_q[s] == ST_EMPTY) begin
                any_empty_c  = 1'b1;
                empty_slot_c = SW'(s);
            end
        end
        win_vld_c = 1'b0;
        win_c     = '0;
        cand_c    = '0;
        for (int k = NW - 1; k >= 0; k--) begin
            cand_c = rr_q + SW'(k);
            if (req[cand_c] && !own_vld_q[cand_c]) begin
                win_vld_c = 1'b1;
                win_c     = cand_c;
            end
        end
        win_vld_c = win_vld_c & any_empty_c;
    end

    // Slot status, ownership, read queue and read FSM next state.
    always_comb begin
        status_d     = status_q;
        own_vld_d    = own_vld_q;
        own_slot_d   = own_slot_q;
        rq_mem_d     = rq_mem_q;
        rq_head_d    = rq_head_q;
        rq_cnt_d     = rq_cnt_q;
        r_state_d    = r_state_q;
        drain_slot_d = drain_slot_q;
        rr_d         = rr_q;
        gnt_d        = '0;
        gnt_slot_d   = '0;
        wr_idx_c     = '0;

        if (flush) begin
            for (int s = 0; s < NS; s++) begin
                status_d[s] = ST_EMPTY;
            end
            own_vld_d = '0;
            rq_head_d = '0;
            rq_cnt_d  = '0;
            r_state_d = R_IDLE;
        end else begin
            if (win_vld_c) begin
                gnt_d[win_c]         = 1'b1;
                gnt_slot_d           = empty_slot_c;
                status_d[empty_slot_c] = ST_ALLOC;
                own_vld_d[win_c]     = 1'b1;
                own_slot_d[win_c]    = empty_slot_c;
                rr_d                 = win_c + SW'(1);
            end

            if (r_state_q == R_OFFER && rd_ack) begin
                status_d[rq_mem_q[rq_head_q]] = ST_DRAIN;
                drain_slot_d = rq_mem_q[rq_head_q];
                rq_head_d    = rq_head_q + SW'(1);
                rq_cnt_d     = rq_cnt_q - CW'(1);
                r_state_d    = R_BUSY;
            end else if (r_state_q == R_BUSY && rd_done) begin
                status_d[drain_slot_q] = ST_EMPTY;
                r_state_d = R_IDLE;
            end

            // Completions enter the queue in ascending writer order.
            for (int w = 0; w < NW; w++) begin
                if (done_wr[w] && own_vld_q[w]) begin
                    status_d[own_slot_q[w]] = ST_FULL;
                    own_vld_d[w]       = 1'b0;
                    wr_idx_c           = rq_head_d + rq_cnt_d[SW-1:0];
                    rq_mem_d[wr_idx_c] = own_slot_q[w];
                    rq_cnt_d           = rq_cnt_d + CW'(1);
                end
            end

            if (r_state_d == R_IDLE && rq_cnt_d != '0) begin
                r_state_d = R_OFFER;
            end
        end

        rd_valid_d   = (r_state_d == R_OFFER);
        rd_slot_d    = rq_mem_d[rq_head_d];
        free_count_d = '0;
        for (int s = 0; s < NS; s++) begin
            if (status_d[s] == ST_EMPTY) begin
                free_count_d = free_count_d + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < NS; s++) begin
                status_q[s] <= ST_EMPTY;
                rq_mem_q[s] <= '0;
            end
            for (int w = 0; w < NW; w++) begin
                own_slot_q[w] <= '0;
            end
            own_vld_q    <= '0;
            rq_head_q    <= '0;
            rq_cnt_q     <= '0;
            r_state_q    <= R_IDLE;
            drain_slot_q <= '0;
            rr_q         <= '0;
            gnt_q        <= '0;
            gnt_slot_q   <= '0;
            rd_valid_q   <= 1'b0;
            rd_slot_q    <= '0;
            free_count_q <= CW'(NS);
        end else begin
            status_q     <= status_d;
            rq_mem_q     <= rq_mem_d;
            own_slot_q   <= own_slot_d;
            own_vld_q    <= own_vld_d;
            rq_head_q    <= rq_head_d;
            rq_cnt_q     <= rq_cnt_d;
            r_state_q    <= r_state_d;
            drain_slot_q <= drain_slot_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            gnt_slot_q   <= gnt_slot_d;
            rd_valid_q   <= rd_valid_d;
            rd_slot_q    <= rd_slot_d;
            free_count_q <= free_count_d;
        end
    end

    always_comb begin
        slot_status = '0;
        for (int s = 0; s < NS; s++) begin
            slot_status[s*SBITS +: SBITS] = status_q[s];
        end
    end

    assign gnt        = gnt_q;
    assign gnt_slot   = gnt_slot_q;
    assign rd_valid   = rd_valid_q;
    assign rd_slot    = rd_slot_q;
    assign free_count = free_count_q;

endmodule

// File: tb/tb_l4_slot_scheduler.sv
// Scoreboard bench for l4_slot_scheduler: a queue-based slot model predicts
// every cycle's outputs; a monitor pops and compares them.
module tb_l4_slot_scheduler;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic [3:0]  req;
    logic [3:0]  done_wr;
    logic [3:0]  gnt;
    logic [1:0]  gnt_slot;
    logic        rd_valid;
    logic [1:0]  rd_slot;
    logic        rd_ack;
    logic        rd_done;
    logic [15:0] slot_status;
    logic [2:0]  free_count;

    l4_slot_scheduler dut (
        .clk(clk), .resetn(resetn), .flush(flush), .req(req), .done_wr(done_wr),
        .gnt(gnt), .gnt_slot(gnt_slot), .rd_valid(rd_valid), .rd_slot(rd_slot),
        .rd_ack(rd_ack), .rd_done(rd_done), .slot_status(slot_status),
        .free_count(free_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  gnt;
        logic [1:0]  gnt_slot;
        logic [15:0] status;
        logic [2:0]  free;
        logic        rd_valid;
        logic [1:0]  rd_slot;
    } exp_t;

    typedef struct {
        int writer;
        int slot;
    } grant_t;

    exp_t   exp_q[$];
    grant_t gq[$];
    int     n_pass  = 0;
    int     n_total = 0;

    // Model: 0 empty, 1 alloc, 2 full, 3 drain; owner -1 means none.
    int m_status[4];
    int m_owner[4];
    int m_q[$];
    bit m_offer;
    int m_drain;
    int m_rr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic m_clear(input bit keep_rr);
        for (int s = 0; s < 4; s++) begin
            m_status[s] = 0;
            m_owner[s]  = -1;
        end
        m_q.delete();
        m_offer = 0;
        m_drain = -1;
        if (!keep_rr) m_rr = 0;
    endtask

    task automatic model_step(input logic fl, input logic [3:0] rq, input logic [3:0] dw,
                              input logic ack, input logic dn);
        exp_t   e;
        grant_t g;
        int     gw = -1;
        int     gs = -1;
        int     nfree = 0;
        if (fl) begin
            m_clear(1);
        end else begin
            for (int s = 0; s < 4; s++) if (gs < 0 && m_status[s] == 0) gs = s;
            if (gs >= 0) begin
                for (int k = 0; k < 4; k++) begin
                    int w = (m_rr + k) % 4;
                    if (gw < 0 && rq[w] && m_owner[w] < 0) gw = w;
                end
            end
            if (m_offer && ack) begin
                int s = m_q.pop_front();
                m_status[s] = 3;
                m_drain = s;
                m_offer = 0;
            end else if (m_drain >= 0 && dn) begin
                m_status[m_drain] = 0;
                m_drain = -1;
            end
            for (int w = 0; w < 4; w++) begin
                if (dw[w] && m_owner[w] >= 0) begin
                    m_status[m_owner[w]] = 2;
                    m_q.push_back(m_owner[w]);
                    m_owner[w] = -1;
                end
            end
            if (gw >= 0) begin
                m_status[gs] = 1;
                m_owner[gw]  = gs;
                m_rr = (gw + 1) % 4;
                g.writer = gw;
                g.slot   = gs;
                gq.push_back(g);
            end
            if (!m_offer && m_drain < 0 && m_q.size() > 0) m_offer = 1;
        end
        e.gnt      = (gw >= 0) ? 4'(1 << gw) : 4'h0;
        e.gnt_slot = (gw >= 0) ? 2'(gs) : 2'd0;
        e.status   = '0;
        for (int s = 0; s < 4; s++) begin
            e.status[s*4 +: 4] = 4'(m_status[s]);
            if (m_status[s] == 0) nfree++;
        end
        e.free     = 3'(nfree);
        e.rd_valid = m_offer;
        e.rd_slot  = m_offer ? 2'(m_q[0]) : 2'd0;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic fl, input logic [3:0] rq, input logic [3:0] dw,
                         input logic ack, input logic dn);
        flush = fl; req = rq; done_wr = dw; rd_ack = ack; rd_done = dn;
        model_step(fl, rq, dw, ack, dn);
    endtask

    task automatic cyc(input logic fl, input logic [3:0] rq, input logic [3:0] dw,
                       input logic ack, input logic dn);
        @(negedge clk);
        drive(fl, rq, dw, ack, dn);
    endtask

    // Look at outputs produced by the edge following the last cyc().
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        flush = 0; req = 0; done_wr = 0; rd_ack = 0; rd_done = 0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_gnt_slot", 32'(gnt_slot), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_rd_slot", 32'(rd_slot), 32'h0);
        chk("rst_status", 32'(slot_status), 32'h0);
        chk("rst_free", 32'(free_count), 32'd4);
        exp_q.delete();
        gq.delete();
        m_clear(0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        drive(0, 4'h0, 4'h0, 0, 0);
    endtask

    // Monitor: every active cycle pops one expected output set.
    initial begin
        exp_t   e;
        grant_t g;
        forever begin
            @(posedge clk);
            #1;
            if (resetn) begin
                chk("exp_avail", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("gnt", 32'(gnt), 32'(e.gnt));
                    chk("gnt_slot", 32'(gnt_slot), 32'(e.gnt_slot));
                    chk("slot_status", 32'(slot_status), 32'(e.status));
                    chk("free_count", 32'(free_count), 32'(e.free));
                    chk("rd_valid", 32'(rd_valid), 32'(e.rd_valid));
                    if (e.rd_valid) chk("rd_slot", 32'(rd_slot), 32'(e.rd_slot));
                end
                if (gnt != 4'h0) begin
                    if (gq.size() == 0) begin
                        chk("gnt_unexpected", 32'(gnt), 32'h0);
                    end else begin
                        g = gq.pop_front();
                        chk("gq_writer", 32'(gnt), 32'(1 << g.writer));
                        chk("gq_slot", 32'(gnt_slot), 32'(g.slot));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rq;
        logic [3:0] dw;
        logic [3:0] g_exp;
        resetn = 1'b0;
        flush = 0; req = 0; done_wr = 0; rd_ack = 0; rd_done = 0;
        m_clear(0);
        do_reset();

        // All writers requesting: one grant per cycle, slots 0..3, then none.
        for (int i = 0; i < 6; i++) begin
            cyc(0, 4'b1111, 4'h0, 0, 0);
            after_edge();
            g_exp = (i < 4) ? 4'(1 << i) : 4'h0;
            chk("seq_gnt", 32'(gnt), 32'(g_exp));
            if (i < 4) chk("seq_gnt_slot", 32'(gnt_slot), 32'(i));
            chk("seq_free", 32'(free_count), 32'((i < 4) ? 3 - i : 0));
        end

        // Completion order decides read order: writer 2 then writer 0.
        cyc(0, 4'h0, 4'b0100, 0, 0);
        after_edge();
        chk("order_first_valid", 32'(rd_valid), 32'd1);
        chk("order_first_slot", 32'(rd_slot), 32'd2);
        cyc(0, 4'h0, 4'b0001, 0, 0);
        cyc(0, 4'h0, 4'h0, 1, 0);
        cyc(0, 4'h0, 4'h0, 0, 1);
        after_edge();
        chk("order_second_valid", 32'(rd_valid), 32'd1);
        chk("order_second_slot", 32'(rd_slot), 32'd0);

        // Same-cycle completions of writers 1 and 3, then drain everything.
        cyc(0, 4'h0, 4'b1010, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 4'h0, 4'h0, 1, 0);
            cyc(0, 4'h0, 4'h0, 0, 1);
        end
        after_edge();
        chk("drained_status", 32'(slot_status), 32'h0);

        // Stray done_wr and rd_done while idle leave everything untouched.
        cyc(0, 4'h0, 4'b0100, 0, 1);
        after_edge();
        chk("stray_status", 32'(slot_status), 32'h0);
        chk("stray_free", 32'(free_count), 32'd4);
        chk("stray_valid", 32'(rd_valid), 32'd0);

        // Fill all slots, then a freed slot is granted only one cycle later.
        for (int i = 0; i < 4; i++) cyc(0, 4'b1111, 4'h0, 0, 0);
        cyc(0, 4'h0, 4'b1111, 0, 0);
        cyc(0, 4'h0, 4'h0, 1, 0);
        cyc(0, 4'b0001, 4'h0, 0, 1);
        after_edge();
        chk("reuse_no_gnt", 32'(gnt), 32'h0);
        cyc(0, 4'b0001, 4'h0, 0, 0);
        after_edge();
        chk("reuse_gnt", 32'(gnt), 32'b0001);
        chk("reuse_gnt_slot", 32'(gnt_slot), 32'd0);

        // Flush with an offer pending and a slot allocated.
        cyc(1, 4'b1111, 4'b1111, 1, 1);
        after_edge();
        chk("flush_status", 32'(slot_status), 32'h0);
        chk("flush_free", 32'(free_count), 32'd4);
        chk("flush_valid", 32'(rd_valid), 32'd0);
        chk("flush_gnt", 32'(gnt), 32'h0);

        // Randomized traffic with a mid-run reset.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            rq = 4'($urandom);
            dw = 4'h0;
            for (int w = 0; w < 4; w++) begin
                if (m_owner[w] >= 0 && $urandom_range(0, 3) == 0) dw[w] = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) dw[$urandom_range(0, 3)] = 1'b1;
            cyc(($urandom_range(0, 63) == 0), rq, dw,
                1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        end
        cyc(0, 4'h0, 4'h0, 0, 0);
        @(posedge clk);
        #5;
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("gq_drained", 32'(gq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
